// File: rtl/mem_arbiter_if.sv
// Two-port memory arbiter bus: requester ports plus data-memory port.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_din;
  logic              dm_we;
  logic [DATA_W-1:0] dm_dout;

  modport slave (
    input  req, we, addr0, addr1,
    input  wdata0, wdata1, dm_dout,
    output gnt, rvalid, rdata, busy,
    output dm_addr, dm_din, dm_we
  );

  modport master (
    output req, we, addr0, addr1,
    output wdata0, wdata1, dm_dout,
    input  gnt, rvalid, rdata, busy,
    input  dm_addr, dm_din, dm_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port sync memory.
// ARB_FIXED_PRIO_EN: port 0 always wins contention instead.
module mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDATA
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_take;
  logic              w_winner;
  logic              r_owner;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_gnt;
  logic [1:0]        r_rvalid;

  // Winner selection and next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    w_winner    = ~bus.req[0];
`else
    w_winner    = (&bus.req) ? ~r_last : bus.req[1];
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_take      = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = r_we ? S_IDLE : S_RDATA;
      end
      S_RDATA: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winning request and produce grant/read-valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      if (w_take) begin
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_gnt   <= w_winner ? 2'b10 : 2'b01;
        r_we    <= bus.we[w_winner];
        r_addr  <= w_winner ? bus.addr1 : bus.addr0;
        r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == S_RDATA) begin
        r_rdata  <= bus.dm_dout;
        r_rvalid <= r_owner ? 2'b10 : 2'b01;
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.dm_addr = r_addr;
  assign bus.dm_din  = r_wdata;
  assign bus.dm_we   = r_we && (r_state == S_ACCESS);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 7, data memory address width; DATA_W, 8, data memory word width.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req  input  2  per-port access request; bit 0 is the SPI-side port, bit 1 is the host port.
REQ-005 we  input  2  per-port write enable (1 = write, 0 = read), qualified by req.
REQ-006 addr0, addr1  input  ADDR_W  per-port address.
REQ-007 wdata0, wdata1  input  DATA_W  per-port write data.
REQ-008 gnt  output  2  one-hot, one-cycle grant pulse.
REQ-009 rvalid  output  2  one-hot, one-cycle read-data-valid pulse.
REQ-010 rdata  output  DATA_W  registered read data, shared by both ports.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 dm_addr  output  ADDR_W  memory address.
REQ-013 dm_din  output  DATA_W  memory write data.
REQ-014 dm_we  output  1  memory write enable.
REQ-015 dm_dout  input  DATA_W  memory read data, valid one cycle after dm_addr is presented.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and RDATA.
REQ-017 req SHALL be sampled only in IDLE; at an edge in IDLE with req != 0, the block SHALL select a winner, latch its addr/we/wdata and owner, go to ACCESS, and register gnt[owner]=1.
REQ-018 gnt SHALL be high only during the ACCESS cycle.
REQ-019 In ACCESS, dm_addr and dm_din SHALL be driven from the latched registers.
REQ-020 dm_we SHALL equal latched we AND (state == ACCESS); dm_we SHALL be 0 in every other state.
REQ-021 On leaving ACCESS, a write SHALL return to IDLE and a read SHALL go to RDATA.
REQ-022 In RDATA, dm_addr SHALL be held.
REQ-023 At the end of RDATA, rdata SHALL capture dm_dout, rvalid[owner] SHALL be set for one cycle, and state SHALL go to IDLE.
REQ-024 Latency: write = 2 cycles (IDLE, ACCESS); read = 3 cycles, with rvalid in the cycle after RDATA.
REQ-025 rvalid SHALL coincide with the next IDLE cycle, so a new arbitration can occur in the same cycle as rvalid.
REQ-026 rdata SHALL hold its value until the next read completes.
REQ-027 Round-robin: a last-owner register SHALL be updated on every grant; when both ports request, the winner SHALL be the port that is not last-owner; a single requester SHALL always win.
REQ-028 A req that drops before IDLE samples it SHALL produce no transaction and no gnt.
REQ-029 A req still high in a later IDLE cycle after its gnt SHALL be treated as a new request; requesters deassert req on the edge that ends their gnt cycle.
REQ-030 req changes during ACCESS or RDATA SHALL be ignored.
REQ-031 Latched addr/we/wdata SHALL NOT change until the next grant.
REQ-032 The address SHALL be used unmodified; wrap-around is the memory's concern.

Reset
REQ-033 When reset is high at an edge, the block SHALL force state=IDLE, gnt=0, rvalid=0, rdata=0, last-owner=1 (port 0 wins the first contended arbitration), and latched registers to 0.
REQ-034 Consequently dm_we=0, busy=0 and dm_addr=0 in the cycle after a reset edge.
REQ-035 Reset mid-transaction SHALL abort it: an in-flight read SHALL produce no rvalid, and a write whose ACCESS cycle coincides with reset SHALL still see dm_we only if it was already driven in that cycle.
REQ-036 reset SHALL override any req sampled at the same edge.

Configuration
REQ-037 Macro ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-038 With ARB_FIXED_PRIO_EN defined, port 0 SHALL always win contention; last-owner SHALL still be maintained but SHALL be unused.
REQ-039 With ARB_FIXED_PRIO_EN undefined, round-robin SHALL apply per REQ-027.
REQ-040 All other behaviour SHALL be identical in both configurations.

Verification
REQ-041 Reset, then req=01, we=01, addr0=0x05, wdata0=0xA5 -> gnt=01 one cycle later; dm_we=1, dm_addr=0x05, dm_din=0xA5 in that cycle; busy low the next cycle.
REQ-042 Port 1 reads 0x05 with a memory model holding 0xA5 -> gnt=10, then RDATA, then rvalid=10 with rdata=0xA5 exactly 3 cycles after the request is sampled.
REQ-043 req=11 held continuously for 4 grants after reset -> round-robin gnt sequence 01,10,01,10; with ARB_FIXED_PRIO_EN defined -> 01,01,01,01.
REQ-044 Read in progress with reset asserted during RDATA -> no rvalid; state IDLE; rdata=0; next req=10 is granted normally.
REQ-045 req0 pulsed high only during an ACCESS cycle of port 1 -> no grant to port 0.
REQ-046 Port 1 write with port 0 read request arriving during the same ACCESS cycle -> port 0 granted in the first IDLE after the write.
